// File: rtl/loas_pkg.sv
// loas_pkg: shared definitions for the LoAS tile fibre-A read path.
//   DEF_TIMESTEPS / DEF_ADDR_WIDTH : default spike word and fibre-A address widths
//   TAG_ID_W                       : id field width carried in read tags
//   tag_t                          : {valid, id} entry of the read tag pipeline
package loas_pkg;

    localparam int DEF_TIMESTEPS  = 4;
    localparam int DEF_ADDR_WIDTH = 8;

    // Tags carry a fixed-width id so the struct can live in the package;
    // it covers up to 256 requesters, far beyond any realistic TPPE count.
    localparam int TAG_ID_W = 8;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter with a registered rotating pointer.
//   clk, rst  : clock, synchronous active-high reset
//   req       : per-requester request vector
//   en        : grant enable (downstream can accept this cycle)
//   gnt       : one-hot grant, combinational
//   gnt_id    : index of the granted requester (valid when gnt_any)
//   gnt_any   : a grant is being given this cycle
module rr_arbiter #(
    parameter int NUM_PE = 4,
    parameter int ID_W   = $clog2(NUM_PE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PE-1:0] req,
    input  logic              en,
    output logic [NUM_PE-1:0] gnt,
    output logic [ID_W-1:0]   gnt_id,
    output logic              gnt_any
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk candidates starting at rr_ptr; the one-bit-wider sum lets the
    // wrap work for any NUM_PE, not only powers of two.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_PE))
                sum = sum - (ID_W+1)'(NUM_PE);
            idx = sum[ID_W-1:0];
            if (en && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (gnt_any)
            rr_ptr <= (gnt_id == ID_W'(NUM_PE-1)) ? '0 : gnt_id + 1'b1;
    end

endmodule

// File: rtl/fibre_rd_arbiter.sv
// fibre_rd_arbiter: shares one fibre-A SRAM read port among NUM_PE TPPEs.
//   clk, rst        : clock, synchronous active-high reset
//   pe_req/pe_addr  : per-PE level request and flattened addresses
//   pe_gnt          : one-hot grant (combinational)
//   pe_rdata        : shared response data (registered)
//   pe_rvalid       : one-hot response pulse (registered)
//   mem_ready       : SRAM can take a read this cycle
//   mem_read_en/addr: registered SRAM read strobe and address
//   mem_rdata/rvalid: SRAM return data and qualifier
//   err_unexpected  : sticky, SRAM returned data with no read in flight
module fibre_rd_arbiter
    import loas_pkg::*;
#(
    parameter int NUM_PE      = 4,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int TIMESTEPS   = DEF_TIMESTEPS,
    parameter int MEM_LATENCY = 2,
    parameter int ID_W        = $clog2(NUM_PE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PE-1:0]            pe_req,
    input  logic [NUM_PE*ADDR_WIDTH-1:0] pe_addr,
    output logic [NUM_PE-1:0]            pe_gnt,
    output logic [TIMESTEPS-1:0]         pe_rdata,
    output logic [NUM_PE-1:0]            pe_rvalid,
    input  logic                         mem_ready,
    output logic                         mem_read_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [TIMESTEPS-1:0]         mem_rdata,
    input  logic                         mem_rvalid,
    output logic                         err_unexpected
);

    localparam int GUARD_W = $clog2(MEM_LATENCY + 2);

    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    tag_t               tag_pipe [0:MEM_LATENCY];
    tag_t               exit_tag;
    logic [NUM_PE-1:0]  exit_onehot;
    logic [GUARD_W-1:0] guard;

    rr_arbiter #(
        .NUM_PE (NUM_PE),
        .ID_W   (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pe_req),
        .en      (mem_ready),
        .gnt     (pe_gnt),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    // Stage k holds the read issued k+1 cycles ago, so the last stage lines
    // up with the cycle the SRAM drives that read's data.
    assign exit_tag = tag_pipe[MEM_LATENCY];

    always_comb begin
        exit_onehot = '0;
        for (int i = 0; i < NUM_PE; i++)
            if (exit_tag.id == TAG_ID_W'(i))
                exit_onehot[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_en    <= 1'b0;
            mem_addr       <= '0;
            pe_rdata       <= '0;
            pe_rvalid      <= '0;
            err_unexpected <= 1'b0;
            // Reads accepted by the SRAM before reset still return; mask
            // the error check until they have drained.
            guard          <= GUARD_W'(MEM_LATENCY + 1);
            for (int k = 0; k <= MEM_LATENCY; k++)
                tag_pipe[k] <= '0;
        end else begin
            mem_read_en <= gnt_any;
            if (gnt_any)
                mem_addr <= pe_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH];

            tag_pipe[0] <= '{valid: gnt_any, id: TAG_ID_W'(gnt_id)};
            for (int k = 1; k <= MEM_LATENCY; k++)
                tag_pipe[k] <= tag_pipe[k-1];

            // Data is taken on the tag alone; mem_rvalid only feeds the
            // error check.
            if (exit_tag.valid) begin
                pe_rdata  <= mem_rdata;
                pe_rvalid <= exit_onehot;
            end else begin
                pe_rvalid <= '0;
            end

            if (guard != '0)
                guard <= guard - 1'b1;
            else if (mem_rvalid && !exit_tag.valid)
                err_unexpected <= 1'b1;
        end
    end

endmodule
